// File: rtl/findstr_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | findstr_pkg : shared types and widths for the findstr arbiter    |
// | Revision    : 1.0                                                |
// +------------------------------------------------------------------+
package findstr_pkg;

   localparam int BYTE_W = 8;
   localparam int CNT_W  = 4;
   localparam int LEN_W  = 16;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      CLEAR  = 3'd1,
      STREAM = 3'd2,
      DRAIN  = 3'd3,
      REPORT = 3'd4
   } state_e;

endpackage
`default_nettype wire

// File: rtl/rr_pick.sv
`default_nettype none
// +------------------------------------------------------------------+
// | rr_pick  : combinational round-robin winner selection            |
// | Revision : 1.0                                                   |
// +------------------------------------------------------------------+
module rr_pick #(
   parameter int N_REQ = 4,
   parameter int IDW   = 2
) (
   input  logic [N_REQ-1:0] req,
   input  logic [IDW-1:0]   last_grant,
   output logic [IDW-1:0]   winner,
   output logic             valid
);

   logic [IDW-1:0] idx;

   // Walk offsets from farthest to nearest so the nearest requester after
   // last_grant is the final assignment and therefore wins.
   always_comb begin
      winner = '0;
      valid  = 1'b0;
      idx    = '0;
      for (int off = N_REQ; off >= 1; off--) begin
         idx = IDW'((int'(last_grant) + off) % N_REQ);
         if (req[idx]) begin
            winner = idx;
            valid  = 1'b1;
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/findstr_arbiter.sv
`default_nettype none
// +------------------------------------------------------------------+
// | findstr_arbiter : round-robin frame scheduler sharing one        |
// |                   findstr matcher between N_REQ byte streams     |
// | Revision        : 1.0                                            |
// +------------------------------------------------------------------+
module findstr_arbiter
   import findstr_pkg::*;
#(
   parameter int N_REQ     = 4,
   parameter int MATCH_LAT = 2,
   parameter int IDW       = 2
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [N_REQ-1:0]        req,
   input  logic [N_REQ-1:0]        s_valid,
   input  logic [BYTE_W*N_REQ-1:0] s_data,
   input  logic [N_REQ-1:0]        s_last,
   output logic [N_REQ-1:0]        s_ready,
   output logic                    m_clr,
   output logic                    m_dv,
   output logic [BYTE_W-1:0]       m_data,
   input  logic [CNT_W-1:0]        m_num,
   output logic [N_REQ-1:0]        done,
   output logic [CNT_W-1:0]        count,
   output logic [LEN_W-1:0]        frame_bytes,
   output logic                    busy,
   output logic [IDW-1:0]          grant_id
);

   localparam int DRN_W = (MATCH_LAT < 1) ? 1 : $clog2(MATCH_LAT + 1);

   state_e            state_q, state_d;
   logic [IDW-1:0]    grant_q, grant_d;
   logic [IDW-1:0]    last_q, last_d;
   logic [LEN_W-1:0]  bytes_q, bytes_d;
   logic [LEN_W-1:0]  frame_q, frame_d;
   logic [CNT_W-1:0]  count_q, count_d;
   logic [DRN_W-1:0]  drain_q, drain_d;
   logic              m_dv_q, m_dv_d;
   logic [BYTE_W-1:0] m_data_q, m_data_d;

   logic [IDW-1:0]    pick_idx;
   logic              pick_valid;
   logic              sel_valid, sel_last, accept;
   logic [BYTE_W-1:0] sel_data;

   rr_pick #(
      .N_REQ (N_REQ),
      .IDW   (IDW)
   ) u_pick (
      .req        (req),
      .last_grant (last_q),
      .winner     (pick_idx),
      .valid      (pick_valid)
   );

   always_comb begin
      sel_valid = 1'b0;
      sel_last  = 1'b0;
      sel_data  = '0;
      for (int i = 0; i < N_REQ; i++) begin
         if (grant_q == IDW'(i)) begin
            sel_valid = s_valid[i];
            sel_last  = s_last[i];
            sel_data  = s_data[i*BYTE_W +: BYTE_W];
         end
      end
   end

   assign accept = (state_q == STREAM) && sel_valid;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         grant_q  <= '0;
         last_q   <= IDW'(N_REQ - 1);
         bytes_q  <= '0;
         frame_q  <= '0;
         count_q  <= '0;
         drain_q  <= '0;
         m_dv_q   <= 1'b0;
         m_data_q <= '0;
      end else begin
         state_q  <= state_d;
         grant_q  <= grant_d;
         last_q   <= last_d;
         bytes_q  <= bytes_d;
         frame_q  <= frame_d;
         count_q  <= count_d;
         drain_q  <= drain_d;
         m_dv_q   <= m_dv_d;
         m_data_q <= m_data_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (pick_valid) state_d = CLEAR;
         CLEAR:   state_d = STREAM;
         STREAM:  if (accept && sel_last) state_d = DRAIN;
         DRAIN:   if (drain_q == '0) state_d = REPORT;
         REPORT:  state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Result registers load on the DRAIN->REPORT edge so count and
   // frame_bytes are already valid in the cycle that carries done.
   always_comb begin
      grant_d  = grant_q;
      last_d   = last_q;
      bytes_d  = bytes_q;
      frame_d  = frame_q;
      count_d  = count_q;
      drain_d  = drain_q;
      m_dv_d   = 1'b0;
      m_data_d = m_data_q;
      unique case (state_q)
         IDLE:   if (pick_valid) grant_d = pick_idx;
         CLEAR:  bytes_d = '0;
         STREAM: begin
            if (accept) begin
               m_dv_d   = 1'b1;
               m_data_d = sel_data;
               if (bytes_q != '1) bytes_d = bytes_q + 1'b1;
               if (sel_last) drain_d = DRN_W'(MATCH_LAT);
            end
         end
         DRAIN: begin
            if (drain_q != '0) begin
               drain_d = drain_q - 1'b1;
            end else begin
               count_d = m_num;
               frame_d = bytes_q;
            end
         end
         REPORT:  last_d = grant_q;
         default: ;
      endcase
   end

   always_comb begin
      s_ready = '0;
      done    = '0;
      m_clr   = 1'b0;
      busy    = (state_q != IDLE);
      unique case (state_q)
         CLEAR:   m_clr = 1'b1;
         STREAM:  s_ready[grant_q] = 1'b1;
         REPORT:  done[grant_q] = 1'b1;
         default: ;
      endcase
   end

   assign m_dv        = m_dv_q;
   assign m_data      = m_data_q;
   assign count       = count_q;
   assign frame_bytes = frame_q;
   assign grant_id    = grant_q;

endmodule
`default_nettype wire

// File: tb/tb_findstr_arbiter.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_findstr_arbiter : directed bench with a behavioural "Welcom"  |
// |                      matcher attached to the m_* port           |
// | Revision           : 1.0                                         |
// +------------------------------------------------------------------+
module tb_findstr_arbiter;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [3:0]  req = '0;
   logic [3:0]  s_valid = '0;
   logic [31:0] s_data = '0;
   logic [3:0]  s_last = '0;
   logic [3:0]  s_ready;
   logic        m_clr;
   logic        m_dv;
   logic [7:0]  m_data;
   logic [3:0]  m_num = '0;
   logic [3:0]  done;
   logic [3:0]  count;
   logic [15:0] frame_bytes;
   logic        busy;
   logic [1:0]  grant_id;

   int n_tests = 0;
   int n_fail  = 0;

   findstr_arbiter #(
      .N_REQ     (4),
      .MATCH_LAT (2),
      .IDW       (2)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .req         (req),
      .s_valid     (s_valid),
      .s_data      (s_data),
      .s_last      (s_last),
      .s_ready     (s_ready),
      .m_clr       (m_clr),
      .m_dv        (m_dv),
      .m_data      (m_data),
      .m_num       (m_num),
      .done        (done),
      .count       (count),
      .frame_bytes (frame_bytes),
      .busy        (busy),
      .grant_id    (grant_id)
   );

   always #5 clk = ~clk;

   // Matcher: counts occurrences of "Welcom", m_num settles two cycles after m_dv.
   logic [47:0] win = '0;
   logic        hit = 1'b0;
   always @(posedge clk) begin
      if (m_clr) begin
         win   <= '0;
         hit   <= 1'b0;
         m_num <= '0;
      end else begin
         if (m_dv) win <= {win[39:0], m_data};
         hit <= m_dv && ({win[39:0], m_data} == 48'h57656C636F6D);
         if (hit) m_num <= m_num + 4'd1;
      end
   end

   int          cyc = 0, clr_cnt = 0, clr_at = 0, first_dv_at = 0, done_at = 0;
   int          done_n = 0, onehot_bad = 0;
   bit          seen_dv = 1'b0;
   logic [31:0] dv_hist = '0;
   logic [3:0]  rdy_mask = 4'hF;
   logic [3:0]  rdy_bad = '0;
   int          grants[$];

   always @(negedge clk) begin
      cyc++;
      dv_hist = {dv_hist[30:0], m_dv};
      if (m_clr) begin
         clr_cnt++;
         clr_at  = cyc;
         seen_dv = 1'b0;
         rdy_bad = '0;
         grants.push_back(int'(grant_id));
      end
      if (m_dv && !seen_dv) begin
         seen_dv     = 1'b1;
         first_dv_at = cyc;
      end
      if (done != '0) begin
         done_n++;
         done_at = cyc;
      end
      if (!$onehot0(s_ready)) onehot_bad++;
      rdy_bad = rdy_bad | (s_ready & ~rdy_mask);
   end

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic send_frame(input int id, input string s, input int nsend, input logic [7:0] vpat);
      int   k = 0;
      int   c = 0;
      int   t = 0;
      logic v;
      while (k < nsend && t < 200) begin
         tick();
         t++;
         if (s_ready[id]) begin
            v = (c < 8) ? vpat[c] : 1'b1;
            c++;
            s_valid[id]         = v;
            s_data[id*8 +: 8]   = s[k];
            s_last[id]          = v && (k == s.len() - 1);
            if (v) k++;
         end else begin
            s_valid[id] = 1'b0;
            s_last[id]  = 1'b0;
         end
      end
      check($sformatf("send%0d_timeout", id), 32'(k < nsend), 32'd0);
      tick();
      s_valid[id] = 1'b0;
      s_last[id]  = 1'b0;
   endtask

   task automatic wait_done(input int budget);
      int t = 0;
      tick();
      while (done == '0 && t < budget) begin
         tick();
         t++;
      end
      check("done_timeout", 32'(done == '0), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: observed no finish, required finish before 200000");
      $fatal(1, "watchdog");
   end

   initial begin
      int c0, g0;

      // Reset state
      tick();
      tick();
      check("rst_busy",     32'(busy),        32'd0);
      check("rst_s_ready",  32'(s_ready),     32'd0);
      check("rst_m_clr",    32'(m_clr),       32'd0);
      check("rst_m_dv",     32'(m_dv),        32'd0);
      check("rst_m_data",   32'(m_data),      32'd0);
      check("rst_done",     32'(done),        32'd0);
      check("rst_count",    32'(count),       32'd0);
      check("rst_frame",    32'(frame_bytes), 32'd0);
      check("rst_grant",    32'(grant_id),    32'd0);
      rst = 1'b0;

      // 1: reset after three bytes of a frame from requester 2
      req = 4'b0100;
      send_frame(2, "Welcom", 3, 8'hFF);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("t1_busy",    32'(busy),     32'd0);
      check("t1_s_ready", 32'(s_ready),  32'd0);
      check("t1_grant",   32'(grant_id), 32'd0);
      check("t1_no_done", 32'(done_n),   32'd0);
      send_frame(2, "Welcom", 6, 8'hFF);
      wait_done(20);
      check("t1_done",   32'(done),        32'h4);
      check("t1_count",  32'(count),       32'd1);
      check("t1_frame",  32'(frame_bytes), 32'd6);
      check("t1_done_n", 32'(done_n),      32'd1);
      req = 4'b0000;

      // 2: single 16-byte frame from requester 0, latency check
      tick();
      c0  = clr_cnt;
      req = 4'b0001;
      send_frame(0, "xxWelcomyyWelcom", 16, 8'hFF);
      wait_done(20);
      check("t2_done",     32'(done),            32'h1);
      check("t2_count",    32'(count),           32'd2);
      check("t2_frame",    32'(frame_bytes),     32'd16);
      check("t2_clr_once", 32'(clr_cnt - c0),    32'd1);
      check("t2_clr_dv",   32'(first_dv_at - clr_at), 32'd2);
      check("t2_latency",  32'(done_at - clr_at),     32'd20);
      req = 4'b0000;

      // 3: all four requesting, round-robin order from a fresh reset
      rst = 1'b1;
      tick();
      rst = 1'b0;
      g0  = grants.size();
      req = 4'hF;
      for (int i = 0; i < 5; i++) begin
         send_frame(i % 4, "Welcom", 6, 8'hFF);
         wait_done(20);
         if (i == 4) req = 4'b0000;
         check($sformatf("t3_done%0d", i),  32'(done),        32'(4'b0001 << (i % 4)));
         check($sformatf("t3_count%0d", i), 32'(count),       32'd1);
         check($sformatf("t3_frame%0d", i), 32'(frame_bytes), 32'd6);
      end
      check("t3_grants", 32'(grants.size() - g0), 32'd5);
      for (int i = 0; i < 5; i++) begin
         if (g0 + i < grants.size())
            check($sformatf("t3_order%0d", i), 32'(grants[g0 + i]), 32'(i % 4));
      end

      // 4: requester 1 with a two-cycle valid gap
      tick();
      rdy_mask = 4'b0010;
      req      = 4'b0010;
      send_frame(1, "ab", 2, 8'b0000_1001);
      wait_done(20);
      check("t4_dv_pattern", 32'(dv_hist[6:0]), 32'(7'b1001000));
      check("t4_done",       32'(done),         32'h2);
      check("t4_frame",      32'(frame_bytes),  32'd2);
      check("t4_count",      32'(count),        32'd0);
      check("t4_rdy_other",  32'(rdy_bad),      32'd0);
      req      = 4'b0000;
      rdy_mask = 4'hF;

      // 5: one-byte frame from 3 while 1 waits, then 1 granted right after
      tick();
      req = 4'b1010;
      send_frame(3, "W", 1, 8'hFF);
      wait_done(20);
      check("t5_done",  32'(done),        32'h8);
      check("t5_frame", 32'(frame_bytes), 32'd1);
      check("t5_count", 32'(count),       32'd0);
      req[3] = 1'b0;
      tick();
      check("t5_idle_busy", 32'(busy),     32'd0);
      tick();
      check("t5_clr",       32'(m_clr),    32'd1);
      check("t5_grant1",    32'(grant_id), 32'd1);
      send_frame(1, "ab", 2, 8'hFF);
      wait_done(20);
      check("t5_done1",  32'(done),        32'h2);
      check("t5_frame1", 32'(frame_bytes), 32'd2);
      req = 4'b0000;

      tick();
      check("s_ready_onehot", 32'(onehot_bad), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
